fm0_frame_rx: RTL and testbench

- Downstream consumer of the FM0 decoder's bit stream (fm0_data qualified by fm0_clk strobes, end marked by fm0_done).
- Re-times the strobes into the base_clk domain and assembles bits MSB-first into bytes.
- Checks frame length against the length expected for cmd_head, and checks the CRC-16 (ISO/IEC 13239).
- Delivers bytes and a frame verdict to the command/protocol controller.

---
 rtl/fm0_frame_rx_if.sv | 28 ++
 rtl/fm0_frame_rx.sv | 179 +++++++++++++++++
 tb/tb_fm0_frame_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fm0_frame_rx_if.sv
// fm0_frame_rx_if: bundles the FM0 decoder bit stream, the command code
// and the byte/verdict outputs delivered to the protocol controller.
//   master : decoder + controller side (drives fm0_*, cmd_head; reads results)
//   slave  : fm0_frame_rx side
interface fm0_frame_rx_if;
    logic       fm0_en;
    logic       fm0_clk;
    logic       fm0_data;
    logic       fm0_done;
    logic [4:0] cmd_head;
    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic [3:0] rx_byte_idx;
    logic [6:0] bit_cnt;
    logic       frame_vld;
    logic       crc_ok;
    logic       len_err;

    modport master (
        output fm0_en, fm0_clk, fm0_data, fm0_done, cmd_head,
        input  rx_byte, rx_byte_vld, rx_byte_idx, bit_cnt, frame_vld, crc_ok, len_err
    );

    modport slave (
        input  fm0_en, fm0_clk, fm0_data, fm0_done, cmd_head,
        output rx_byte, rx_byte_vld, rx_byte_idx, bit_cnt, frame_vld, crc_ok, len_err
    );
endinterface

// File: rtl/fm0_frame_rx.sv
// fm0_frame_rx: re-times FM0 decoder strobes into base_clk, assembles bits
// MSB-first into bytes, checks frame length against the command's expected
// length and checks the CRC-16 (poly 0x1021) residue.
// Ports:
//   base_clk : system clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : fm0_frame_rx_if.slave (decoder inputs, cmd_head, byte and
//              verdict outputs; all outputs registered)
module fm0_frame_rx #(
    parameter logic [15:0] CRC_PRESET  = 16'hFFFF,
    parameter logic [15:0] CRC_RESIDUE = 16'h1D0F,
    parameter logic [6:0]  MAX_BITS    = 7'd127
) (
    input  logic          base_clk,
    input  logic          rst_n,
    fm0_frame_rx_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK, ST_DONE} state_t;

    // One serial CRC-16 step, MSB-first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Expected frame length in bits (CRC included); 0 means undefined
    function automatic logic [6:0] exp_len_of(input logic [4:0] cmd);
        case (cmd)
            5'd3:                          return 7'd16;
            5'd2:                          return 7'd64;
            5'd7, 5'd8, 5'd14, 5'd15:      return 7'd40;
            5'd17, 5'd18, 5'd19:           return 7'd80;
            5'd9, 5'd10:                   return 7'd96;
            default:                       return 7'd0;
        endcase
    endfunction

    logic [1:0]  clk_sync_r;
    logic [1:0]  data_sync_r;
    logic [1:0]  done_sync_r;
    logic        clk_dly_r;
    logic        done_dly_r;
    logic        bit_p_r;
    logic        done_p_r;

    state_t      state_r;
    logic [4:0]  cmd_r;
    logic [15:0] crc_r;
    logic [7:0]  shift_r;
    logic [6:0]  bit_cnt_r;
    logic [7:0]  rx_byte_r;
    logic        rx_byte_vld_r;
    logic [3:0]  rx_byte_idx_r;
    logic        frame_vld_r;
    logic        crc_ok_r;
    logic        len_err_r;

    logic [7:0]  shift_nxt_s;
    logic [15:0] crc_nxt_s;
    logic [6:0]  cnt_nxt_s;
    logic [6:0]  exp_len_s;
    logic        len_bad_s;
    logic        recv_end_s;

    // Two-flop synchronisers plus registered rising-edge detects
    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= 2'b00;
            data_sync_r <= 2'b00;
            done_sync_r <= 2'b00;
            clk_dly_r   <= 1'b0;
            done_dly_r  <= 1'b0;
            bit_p_r     <= 1'b0;
            done_p_r    <= 1'b0;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], bus.fm0_clk};
            data_sync_r <= {data_sync_r[0], bus.fm0_data};
            done_sync_r <= {done_sync_r[0], bus.fm0_done};
            clk_dly_r   <= clk_sync_r[1];
            done_dly_r  <= done_sync_r[1];
            bit_p_r     <= clk_sync_r[1] & ~clk_dly_r;
            done_p_r    <= done_sync_r[1] & ~done_dly_r;
        end
    end

    // Next-bit values, length verdict and end-of-reception condition
    always_comb begin
        shift_nxt_s = {shift_r[6:0], data_sync_r[1]};
        crc_nxt_s   = crc16_step(crc_r, data_sync_r[1]);
        cnt_nxt_s   = bit_cnt_r + 7'd1;
        exp_len_s   = exp_len_of(cmd_r);
        len_bad_s   = ((exp_len_s != 7'd0) && (bit_cnt_r != exp_len_s)) ||
                      (bit_cnt_r[2:0] != 3'd0) ||
                      (bit_cnt_r < 7'd16) ||
                      ((bit_cnt_r == MAX_BITS) && (exp_len_s == 7'd0));
        // A bit arriving together with done_p is still accepted this cycle
        recv_end_s  = done_p_r ||
                      (bit_p_r && (((exp_len_s != 7'd0) && (cnt_nxt_s == exp_len_s)) ||
                                   (cnt_nxt_s == MAX_BITS)));
    end

    // Frame FSM with registered byte and verdict outputs
    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cmd_r         <= 5'd0;
            crc_r         <= CRC_PRESET;
            shift_r       <= 8'd0;
            bit_cnt_r     <= 7'd0;
            rx_byte_r     <= 8'd0;
            rx_byte_vld_r <= 1'b0;
            rx_byte_idx_r <= 4'd0;
            frame_vld_r   <= 1'b0;
            crc_ok_r      <= 1'b0;
            len_err_r     <= 1'b0;
        end else begin
            rx_byte_vld_r <= 1'b0;
            frame_vld_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.fm0_en) begin
                        state_r   <= ST_RECV;
                        cmd_r     <= bus.cmd_head;
                        crc_r     <= CRC_PRESET;
                        shift_r   <= 8'd0;
                        bit_cnt_r <= 7'd0;
                        crc_ok_r  <= 1'b0;
                        len_err_r <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (!bus.fm0_en) begin
                        state_r <= ST_IDLE;
                    end else begin
                        if (bit_p_r) begin
                            shift_r   <= shift_nxt_s;
                            crc_r     <= crc_nxt_s;
                            bit_cnt_r <= cnt_nxt_s;
                            if (cnt_nxt_s[2:0] == 3'd0) begin
                                rx_byte_r     <= shift_nxt_s;
                                rx_byte_vld_r <= 1'b1;
                                rx_byte_idx_r <= cnt_nxt_s[6:3] - 4'd1;
                            end
                        end
                        if (recv_end_s) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    len_err_r   <= len_bad_s;
                    crc_ok_r    <= (crc_r == CRC_RESIDUE) && !len_bad_s;
                    frame_vld_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    // Late strobes are ignored; results are held
                    if (!bus.fm0_en) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_byte     = rx_byte_r;
    assign bus.rx_byte_vld = rx_byte_vld_r;
    assign bus.rx_byte_idx = rx_byte_idx_r;
    assign bus.bit_cnt     = bit_cnt_r;
    assign bus.frame_vld   = frame_vld_r;
    assign bus.crc_ok      = crc_ok_r;
    assign bus.len_err     = len_err_r;

endmodule

// File: tb/tb_fm0_frame_rx.sv
// Self-checking bench for fm0_frame_rx: table of frames plus hand-written
// abort, asynchronous reset and done-aligned sequences. Expected bytes are
// queued as bits are driven and compared when rx_byte_vld pulses.
module tb_fm0_frame_rx;

    logic base_clk;
    logic rst_n;

    fm0_frame_rx_if bus ();

    fm0_frame_rx dut (
        .base_clk (base_clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    initial base_clk = 1'b0;
    always #5 base_clk = ~base_clk;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [4:0] cmd;
        int         nbits;
        int         kind;      // 0 zeros, 1 12/34/56+crc, 2 same with a flipped bit, 3 pattern, 4 A5+crc
        int         done_mode; // 0 none, 1 after last bit, 2 with last bit
        int         exp_cnt;
        logic       exp_crc;
        logic       exp_len;
    } vec_t;

    int   tests;
    int   fails;
    int   frame_cnt;
    exp_t exp_q[$];
    logic bits_q[$];
    int   model_cnt;
    int   model_limit;
    logic [7:0] model_shift;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock step, sampled on the falling edge; scoreboard lives here
    task automatic tick();
        exp_t e;
        @(negedge base_clk);
        if (bus.rx_byte_vld) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL byte_extra: got idx %0d byte %0h expected no byte", bus.rx_byte_idx, bus.rx_byte);
            end else begin
                e = exp_q.pop_front();
                check("rx_byte", {24'd0, bus.rx_byte}, {24'd0, e.b});
                check("rx_byte_idx", {28'd0, bus.rx_byte_idx}, {28'd0, e.idx});
            end
        end
        if (bus.frame_vld) frame_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_start(input int limit);
        model_cnt   = 0;
        model_limit = limit;
        model_shift = 8'd0;
    endtask

    task automatic send_bit(input logic b, input logic with_done);
        exp_t e;
        if (model_cnt < model_limit) begin
            model_shift = {model_shift[6:0], b};
            model_cnt++;
            if (model_cnt % 8 == 0) begin
                e.idx = 4'((model_cnt / 8) - 1);
                e.b   = model_shift;
                exp_q.push_back(e);
            end
        end
        bus.fm0_data = b;
        bus.fm0_clk  = 1'b1;
        bus.fm0_done = with_done;
        ticks(4);
        bus.fm0_clk  = 1'b0;
        bus.fm0_done = 1'b0;
        ticks(4);
    endtask

    task automatic send_done();
        bus.fm0_done = 1'b1;
        ticks(4);
        bus.fm0_done = 1'b0;
        ticks(4);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
    endtask

    // Bench CRC over the queued bits, then append its complement
    task automatic append_crc();
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        foreach (bits_q[i]) begin
            fb = c[15] ^ bits_q[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        c = ~c;
        push_byte(c[15:8]);
        push_byte(c[7:0]);
    endtask

    task automatic build_bits(input int kind, input int nbits);
        logic [7:0] p;
        bits_q.delete();
        case (kind)
            1, 2: begin
                push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
                append_crc();
                if (kind == 2) bits_q[5] = ~bits_q[5];
            end
            3: begin
                for (int i = 0; i < (nbits + 7) / 8; i++) begin
                    p = 8'(i * 37 + 5);
                    push_byte(p);
                end
                while (bits_q.size() > nbits) void'(bits_q.pop_back());
            end
            4: begin
                push_byte(8'hA5);
                append_crc();
            end
            default: begin
                for (int i = 0; i < nbits; i++) bits_q.push_back(1'b0);
            end
        endcase
    endtask

    task automatic wait_verdict(input int base, input string name);
        for (int k = 0; k < 40 && frame_cnt == base; k++) tick();
        check({name, "_frame_vld_cnt"}, 32'(frame_cnt - base), 32'd1);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int base;
        bus.cmd_head = v.cmd;
        bus.fm0_en   = 1'b1;
        model_start(v.exp_cnt);
        ticks(3);
        base = frame_cnt;
        build_bits(v.kind, v.nbits);
        for (int i = 0; i < bits_q.size(); i++)
            send_bit(bits_q[i], (v.done_mode == 2) && (i == bits_q.size() - 1));
        if (v.done_mode == 1) send_done();
        wait_verdict(base, name);
        ticks(4);
        check({name, "_frame_vld_once"}, 32'(frame_cnt - base), 32'd1);
        check({name, "_crc_ok"}, {31'd0, bus.crc_ok}, {31'd0, v.exp_crc});
        check({name, "_len_err"}, {31'd0, bus.len_err}, {31'd0, v.exp_len});
        check({name, "_bit_cnt"}, {25'd0, bus.bit_cnt}, 32'(v.exp_cnt));
        check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        bus.fm0_en = 1'b0;
        ticks(3);
    endtask

    vec_t vecs[8];

    initial begin
        int base;
        tests = 0; fails = 0; frame_cnt = 0;
        vecs[0] = '{cmd: 5'd3, nbits: 16,  kind: 0, done_mode: 0, exp_cnt: 16,  exp_crc: 1'b1, exp_len: 1'b0};
        vecs[1] = '{cmd: 5'd7, nbits: 40,  kind: 1, done_mode: 0, exp_cnt: 40,  exp_crc: 1'b1, exp_len: 1'b0};
        vecs[2] = '{cmd: 5'd7, nbits: 40,  kind: 2, done_mode: 0, exp_cnt: 40,  exp_crc: 1'b0, exp_len: 1'b0};
        vecs[3] = '{cmd: 5'd9, nbits: 50,  kind: 3, done_mode: 1, exp_cnt: 50,  exp_crc: 1'b0, exp_len: 1'b1};
        vecs[4] = '{cmd: 5'd3, nbits: 20,  kind: 0, done_mode: 0, exp_cnt: 16,  exp_crc: 1'b1, exp_len: 1'b0};
        vecs[5] = '{cmd: 5'd0, nbits: 24,  kind: 4, done_mode: 1, exp_cnt: 24,  exp_crc: 1'b1, exp_len: 1'b0};
        vecs[6] = '{cmd: 5'd0, nbits: 130, kind: 3, done_mode: 0, exp_cnt: 127, exp_crc: 1'b0, exp_len: 1'b1};
        vecs[7] = '{cmd: 5'd2, nbits: 12,  kind: 3, done_mode: 1, exp_cnt: 12,  exp_crc: 1'b0, exp_len: 1'b1};

        bus.fm0_en = 1'b0; bus.fm0_clk = 1'b0; bus.fm0_data = 1'b0;
        bus.fm0_done = 1'b0; bus.cmd_head = 5'd0;
        rst_n = 1'b0;
        ticks(3);
        check("reset_outputs",
              {9'd0, bus.rx_byte, bus.rx_byte_vld, bus.rx_byte_idx, bus.bit_cnt,
               bus.frame_vld, bus.crc_ok, bus.len_err}, 32'd0);
        rst_n = 1'b1;
        ticks(2);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Abort mid-frame: no verdict, flags stay cleared
        base = frame_cnt;
        bus.cmd_head = 5'd2;
        bus.fm0_en   = 1'b1;
        model_start(64);
        ticks(3);
        build_bits(3, 30);
        for (int i = 0; i < 30; i++) send_bit(bits_q[i], 1'b0);
        bus.fm0_en = 1'b0;
        ticks(20);
        check("abort_no_frame_vld", 32'(frame_cnt - base), 32'd0);
        check("abort_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
        check("abort_len_err", {31'd0, bus.len_err}, 32'd0);
        check("abort_bytes_left", 32'(exp_q.size()), 32'd0);
        run_frame(vecs[0], "after_abort");

        // Asynchronous reset in the middle of a 40-bit frame
        bus.cmd_head = 5'd7;
        bus.fm0_en   = 1'b1;
        model_start(40);
        ticks(3);
        build_bits(1, 40);
        for (int i = 0; i < 20; i++) send_bit(bits_q[i], 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {9'd0, bus.rx_byte, bus.rx_byte_vld, bus.rx_byte_idx, bus.bit_cnt,
               bus.frame_vld, bus.crc_ok, bus.len_err}, 32'd0);
        check("midreset_bytes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        bus.fm0_en = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        run_frame(vecs[1], "after_reset");

        // fm0_done arrives together with the final bit strobe
        run_frame('{cmd: 5'd0, nbits: 24, kind: 4, done_mode: 2, exp_cnt: 24,
                    exp_crc: 1'b1, exp_len: 1'b0}, "done_aligned");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
